// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester IDs and the read-latency constant of the memory block.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // Requester IDs double as bit positions in the req/gnt vectors
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Memory read data appears one cycle after the address/MemRead issue
  localparam int RD_LAT = 1;

  // Control fields latched for the transaction in flight
  typedef struct packed {
    logic owner;  // REQ_IF / REQ_D
    logic we;     // 1 = store
  } txn_ctl_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The arbiter uses the
// slave view; the datapath/memory environment uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wrdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_read, mem_write, mem_wrdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_read, mem_write, mem_wrdata, busy
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester always wins; on contention
// the requester that was not served last wins. Grant is one-hot or zero.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // pick winner from the request vector and last-winner pointer
  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (last == REQ_D) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction at a time: IDLE samples requests, ACCESS issues the
// address/control, WAIT covers the synchronous read, and read data is
// returned from per-requester registers the cycle after WAIT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_t            state, state_nx;
  logic              last_q;
  txn_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [1:0]        req, gnt;
  logic              take;

  assign req  = {bus.d_req, bus.if_req};
  assign take = (state == ST_IDLE) && (|req);

  rr_arb2 u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // next state: stores finish after ACCESS, reads go through WAIT
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (|req) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ctl_q.we ? ST_IDLE : ST_WAIT;
      ST_WAIT:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // memory control and grant pulses decoded from state
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    case (state)
      ST_ACCESS: begin
        bus.mem_read  = ~ctl_q.we;
        bus.mem_write = ctl_q.we;
        bus.if_gnt    = (ctl_q.owner == REQ_IF);
        bus.d_gnt     = (ctl_q.owner == REQ_D);
      end
      ST_WAIT: bus.mem_read = 1'b1;
      default: ;
    endcase
  end

  // latch the winner's operands; fetches never write
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= REQ_D;
      ctl_q   <= '{owner: REQ_IF, we: 1'b0};
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      last_q      <= gnt[REQ_D];
      ctl_q.owner <= gnt[REQ_D];
      if (gnt[REQ_D]) begin
        ctl_q.we <= bus.d_we;
        addr_q   <= bus.d_addr;
        wdata_q  <= bus.d_wdata;
      end else begin
        ctl_q.we <= 1'b0;
        addr_q   <= bus.if_addr;
        wdata_q  <= '0;
      end
    end
  end

  // capture read data at the end of WAIT into the owner's return register
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= (state == ST_WAIT) && (ctl_q.owner == REQ_IF);
      d_rvalid_q  <= (state == ST_WAIT) && (ctl_q.owner == REQ_D);
      if (state == ST_WAIT) begin
        if (ctl_q.owner == REQ_D) d_rdata_q  <= bus.mem_rdata;
        else                      if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wrdata = wdata_q;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.d_rvalid   = d_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requesters are fed from stimulus queues, a
// transaction-level model predicts grant order and read data, and a
// negedge monitor checks every grant/rvalid against the predictions.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { bit who; logic [31:0] addr; bit we; logic [31:0] wdata; } txn_t;
  typedef struct { bit who; logic [31:0] data; } rv_t;

  txn_t if_q[$], d_q[$], exp_gnt[$];
  rv_t  exp_rv[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   if_gnt_cycs[$], d_gnt_cycs[$];
  bit   gnt_order[$];
  int   c0;
  bit   m_last;
  logic [31:0] m_if_rd, m_d_rd;
  logic [31:0] ref_mem [0:16383];

  // memory environment: synchronous read, write at end of ACCESS
  logic [31:0]    env_mem [0:16383];
  logic [16383:0] env_wr;

  function automatic logic [31:0] seed(int i);
    if (i == 4) return 32'h8C010004;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_clr) env_wr <= '0;
    else if (bus.mem_write) begin
      env_mem[bus.mem_addr[15:2]] <= bus.mem_wrdata;
      env_wr[bus.mem_addr[15:2]]  <= 1'b1;
    end
    if (bus.mem_read)
      bus.mem_rdata <= env_wr[bus.mem_addr[15:2]] ? env_mem[bus.mem_addr[15:2]]
                                                  : seed(int'(bus.mem_addr[15:2]));
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops predictions whenever the DUT presents a grant or rvalid
  int   wait_cyc = -1, rv_cyc = -1, st_cyc = -1;
  logic [31:0] held_addr;
  txn_t mon_e;
  rv_t  mon_r;

  always @(negedge clk) begin
    if (rst) begin
      wait_cyc = -1; rv_cyc = -1; st_cyc = -1;
    end else begin
      if (bus.if_gnt || bus.d_gnt) begin
        chk("gnt_onehot", 64'(bus.if_gnt & bus.d_gnt), 0);
        chk("gnt_expected", 64'(exp_gnt.size() != 0), 1);
        if (exp_gnt.size() != 0) begin
          mon_e = exp_gnt.pop_front();
          chk("gnt_who", 64'(bus.d_gnt), 64'(mon_e.who));
          chk("gnt_mem_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
          chk("gnt_mem_write", 64'(bus.mem_write), 64'(mon_e.we));
          chk("gnt_mem_read", 64'(bus.mem_read), 64'(!mon_e.we));
          chk("gnt_busy", 64'(bus.busy), 1);
          if (mon_e.we) begin
            chk("gnt_mem_wrdata", 64'(bus.mem_wrdata), 64'(mon_e.wdata));
            st_cyc = cyc + 1;
          end else begin
            wait_cyc  = cyc + 1;
            rv_cyc    = cyc + 2;
            held_addr = mon_e.addr;
          end
        end
      end
      if (cyc == wait_cyc) begin
        chk("wait_mem_read", 64'(bus.mem_read), 1);
        chk("wait_mem_write", 64'(bus.mem_write), 0);
        chk("wait_addr_held", 64'(bus.mem_addr), 64'(held_addr));
        chk("wait_busy", 64'(bus.busy), 1);
        chk("wait_no_gnt", 64'(bus.if_gnt | bus.d_gnt), 0);
      end
      if (cyc == st_cyc) begin
        chk("store_write_one_cycle", 64'(bus.mem_write), 0);
        chk("store_idle_busy", 64'(bus.busy), 0);
      end
      if (bus.if_rvalid || bus.d_rvalid || cyc == rv_cyc) begin
        chk("rvalid_present", 64'(bus.if_rvalid | bus.d_rvalid), 1);
        chk("rvalid_onehot", 64'(bus.if_rvalid & bus.d_rvalid), 0);
        chk("rvalid_timing", 64'(cyc), 64'(rv_cyc));
        if (bus.if_rvalid || bus.d_rvalid) begin
          chk("rvalid_expected", 64'(exp_rv.size() != 0), 1);
          if (exp_rv.size() != 0) begin
            mon_r = exp_rv.pop_front();
            chk("rvalid_who", 64'(bus.d_rvalid), 64'(mon_r.who));
            chk("rdata", 64'(mon_r.who ? bus.d_rdata : bus.if_rdata), 64'(mon_r.data));
          end
        end
        if (cyc == rv_cyc) rv_cyc = -1;
      end
      if (bus.mem_write) chk("write_only_with_gnt", 64'(bus.d_gnt), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive();
    bus.if_req  = (if_q.size() != 0);
    bus.if_addr = (if_q.size() != 0) ? if_q[0].addr : $urandom;
    if (d_q.size() != 0) begin
      bus.d_req   = 1'b1;
      bus.d_we    = d_q[0].we;
      bus.d_addr  = d_q[0].addr;
      bus.d_wdata = d_q[0].wdata;
    end else begin
      bus.d_req   = 1'b0;
      bus.d_we    = 1'($urandom_range(0, 1));
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
    end
  endtask

  // one cycle: retire a granted request, then present the next one
  task automatic step();
    @(negedge clk);
    if (bus.if_gnt) begin
      if_gnt_cycs.push_back(cyc);
      gnt_order.push_back(1'b0);
      if (if_q.size() != 0) if_q.delete(0);
    end
    if (bus.d_gnt) begin
      d_gnt_cycs.push_back(cyc);
      gnt_order.push_back(1'b1);
      if (d_q.size() != 0) d_q.delete(0);
    end
    drive();
  endtask

  task automatic add_if(logic [31:0] a);
    txn_t t;
    t.who = 1'b0; t.addr = a; t.we = 1'b0; t.wdata = '0;
    if_q.push_back(t);
  endtask

  task automatic add_d(bit we, logic [31:0] a, logic [31:0] wd);
    txn_t t;
    t.who = 1'b1; t.addr = a; t.we = we; t.wdata = wd;
    d_q.push_back(t);
  endtask

  // reference model: serve pending requests in round-robin order over a
  // word-addressed memory image, producing grants and read returns
  task automatic build();
    txn_t a[$], b[$];
    a = if_q;
    b = d_q;
    while (a.size() != 0 || b.size() != 0) begin
      bit   pick;
      txn_t t;
      rv_t  r;
      if (a.size() != 0 && b.size() != 0) pick = ~m_last;
      else                                pick = (b.size() != 0);
      if (pick) begin t = b[0]; b.delete(0); end
      else      begin t = a[0]; a.delete(0); end
      m_last = pick;
      exp_gnt.push_back(t);
      if (t.we) ref_mem[t.addr[15:2]] = t.wdata;
      else begin
        r.who  = pick;
        r.data = ref_mem[t.addr[15:2]];
        exp_rv.push_back(r);
        if (pick) m_d_rd = r.data;
        else      m_if_rd = r.data;
      end
    end
  endtask

  function automatic bit drained();
    return if_q.size() == 0 && d_q.size() == 0 && exp_gnt.size() == 0 && exp_rv.size() == 0;
  endfunction

  task automatic flush();
    if_q.delete(); d_q.delete(); exp_gnt.delete(); exp_rv.delete();
  endtask

  task automatic run(int bound);
    int n;
    if_gnt_cycs.delete(); d_gnt_cycs.delete(); gnt_order.delete();
    build();
    step();
    c0 = cyc;
    n = 0;
    while (!drained() && n < bound) begin step(); n++; end
    chk("phase_drained", 64'(drained()), 1);
    step(); step();
    chk("if_rdata_hold", 64'(bus.if_rdata), 64'(m_if_rd));
    chk("d_rdata_hold", 64'(bus.d_rdata), 64'(m_d_rd));
    if (!drained()) flush();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    m_last = 1'b1; m_if_rd = '0; m_d_rd = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = seed(i);
    m_last = 1'b1; m_if_rd = '0; m_d_rd = '0;
    drive();
    repeat (3) step();
    mem_clr = 1'b0;
    rst = 1'b0;
    step();

    // reset state of every output
    chk("rst_if_gnt", 64'(bus.if_gnt), 0);
    chk("rst_if_rvalid", 64'(bus.if_rvalid), 0);
    chk("rst_if_rdata", 64'(bus.if_rdata), 0);
    chk("rst_d_gnt", 64'(bus.d_gnt), 0);
    chk("rst_d_rvalid", 64'(bus.d_rvalid), 0);
    chk("rst_d_rdata", 64'(bus.d_rdata), 0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 0);
    chk("rst_mem_read", 64'(bus.mem_read), 0);
    chk("rst_mem_write", 64'(bus.mem_write), 0);
    chk("rst_mem_wrdata", 64'(bus.mem_wrdata), 0);
    chk("rst_busy", 64'(bus.busy), 0);

    // single fetch: grant one cycle after the sampling edge
    add_if(32'h0000_0010);
    run(50);
    chk("fetch_gnt_latency", 64'(if_gnt_cycs.size() == 1 ? if_gnt_cycs[0] - c0 : -1), 1);
    chk("fetch_rdata", 64'(bus.if_rdata), 64'h8C010004);

    // store then load back
    add_d(1'b1, 32'h0000_0020, 32'hDEADBEEF);
    add_d(1'b0, 32'h0000_0020, 32'h0);
    run(50);
    chk("load_after_store", 64'(bus.d_rdata), 64'hDEADBEEF);

    // contention from reset alternates IF, D, IF, D
    do_reset();
    add_if(32'h100); add_if(32'h104);
    add_d(1'b0, 32'h200, 32'h0); add_d(1'b0, 32'h204, 32'h0);
    run(80);
    chk("rr_grant_count", 64'(gnt_order.size()), 4);
    for (int i = 0; i < 4 && i < gnt_order.size(); i++)
      chk($sformatf("rr_order_%0d", i), 64'(gnt_order[i]), 64'(i % 2));

    // back-to-back loads from the data port only: one per 3 cycles
    for (int i = 0; i < 3; i++) add_d(1'b0, 32'h300 + 32'(4 * i), 32'h0);
    run(80);
    chk("loads_if_gnt_none", 64'(if_gnt_cycs.size()), 0);
    chk("loads_gnt_count", 64'(d_gnt_cycs.size()), 3);
    for (int i = 1; i < d_gnt_cycs.size(); i++)
      chk("load_spacing", 64'(d_gnt_cycs[i] - d_gnt_cycs[i-1]), 3);

    // back-to-back stores: one per 2 cycles
    for (int i = 0; i < 3; i++) add_d(1'b1, 32'h400 + 32'(4 * i), 32'(i + 32'h77));
    run(80);
    chk("stores_gnt_count", 64'(d_gnt_cycs.size()), 3);
    for (int i = 1; i < d_gnt_cycs.size(); i++)
      chk("store_spacing", 64'(d_gnt_cycs[i] - d_gnt_cycs[i-1]), 2);

    // reset while a fetch is in WAIT: discarded without rvalid
    begin
      int k;
      if_gnt_cycs.delete();
      add_if(32'h0000_0040);
      build();
      k = 0;
      do begin step(); k++; end while (if_gnt_cycs.size() == 0 && k < 10);
      chk("rstwait_gnt_seen", 64'(if_gnt_cycs.size()), 1);
      step();
      chk("rstwait_in_wait", 64'(bus.mem_read & bus.busy), 1);
      rst = 1'b1;
      step();
      chk("rstwait_if_rvalid", 64'(bus.if_rvalid), 0);
      chk("rstwait_busy", 64'(bus.busy), 0);
      chk("rstwait_mem_read", 64'(bus.mem_read), 0);
      chk("rstwait_mem_write", 64'(bus.mem_write), 0);
      chk("rstwait_mem_addr", 64'(bus.mem_addr), 0);
      chk("rstwait_if_rdata", 64'(bus.if_rdata), 0);
      chk("rstwait_d_rdata", 64'(bus.d_rdata), 0);
      flush();
      m_last = 1'b1; m_if_rd = '0; m_d_rd = '0;
      step();
      rst = 1'b0;
      step();
      chk("rstwait_no_late_rvalid", 64'(bus.if_rvalid), 0);
    end
    add_if(32'h0000_0010);
    run(50);

    // store to the output-port address
    add_d(1'b1, 32'h0000_FFFC, 32'h5);
    run(50);
    chk("outport_mem_word", 64'(env_mem[14'h3FFF]), 5);

    // randomized mixed traffic
    for (int r = 0; r < 10; r++) begin
      int ni, nd;
      ni = $urandom_range(0, 4);
      nd = $urandom_range(0, 4);
      for (int i = 0; i < ni; i++) add_if(32'($urandom_range(0, 16'hFFFF)));
      for (int i = 0; i < nd; i++)
        add_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 16'hFFFF)), $urandom);
      run(200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
